// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD digit type, digit limit, countdown state enum and digit clamp helper
package bcd_pkg;
  typedef logic [3:0] bcd_digit_t;
  localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} bcd_cnt_state_t;
  function automatic bcd_digit_t bcd_sanitize(input bcd_digit_t d);
    return d > BCD_MAX_DIGIT ? BCD_MAX_DIGIT : d;
  endfunction
endpackage

// File: rtl/bcd_digit_dec.sv
// bcd_digit_dec: single BCD digit decrement with borrow chain, purely combinational
module bcd_digit_dec
  import bcd_pkg::*;
(
  input  logic [3:0] d,
  input  logic       borrow_in,
  output logic [3:0] q,
  output logic       borrow_out
);
  assign q = !borrow_in ? d : (d == 4'd0 ? BCD_MAX_DIGIT : d - 4'd1);
  assign borrow_out = borrow_in & (d == 4'd0);
endmodule

// File: rtl/bcd_down_counter.sv
// bcd_down_counter: loadable packed-BCD countdown timer with prescaler, pause/resume and done pulse; BCD_DOWN_RELOAD_EN adds auto-reload at zero
module bcd_down_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 3,
  parameter int PRESCALE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                start,
  input  logic                pause,
  input  logic                tick,
  output logic [4*DIGITS-1:0] count,
  output logic                busy,
  output logic                done,
  output logic                invalid
);
  localparam int W  = 4*DIGITS;
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  bcd_cnt_state_t state, state_nx;
  logic [PW-1:0] presc, presc_nx;
  logic [W-1:0] count_nx, clean, dec_raw, dec, reload_val;
  logic [DIGITS:0] brw;
  logic clamp, done_nx, invalid_nx, busy_nx;
  // clamp each preset digit to 9 and flag whether any clamping happened
  always_comb begin
    clamp = 1'b0;
    clean = '0;
    for (int k = 0; k < DIGITS; k++) begin
      clean[4*k+:4] = bcd_sanitize(load_val[4*k+:4]);
      clamp = clamp | (load_val[4*k+:4] > BCD_MAX_DIGIT);
    end
  end
  assign brw[0] = 1'b1;
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_digit_dec u_dig (
      .d         (count[4*i+:4]),
      .borrow_in (brw[i]),
      .q         (dec_raw[4*i+:4]),
      .borrow_out(brw[i+1])
    );
  end
  // a borrow out of the top digit means the count is already zero, so hold instead of wrapping
  assign dec = brw[DIGITS] ? count : dec_raw;
`ifdef BCD_DOWN_RELOAD_EN
  // reload value tracks the sanitized preset of the most recent load
  always_ff @(posedge clk)
    if (!rst_n) reload_val <= '0;
    else if (load) reload_val <= clean;
`else
  assign reload_val = '0;
`endif
  // state register and registered outputs
  always_ff @(posedge clk)
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      presc   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      invalid <= 1'b0;
    end else begin
      state   <= state_nx;
      count   <= count_nx;
      presc   <= presc_nx;
      busy    <= busy_nx;
      done    <= done_nx;
      invalid <= invalid_nx;
    end
  // next-state, count and prescaler; load overrides everything, control beats tick
  always_comb begin
    state_nx   = state;
    count_nx   = count;
    presc_nx   = presc;
    done_nx    = 1'b0;
    invalid_nx = 1'b0;
    if (load) begin
      state_nx   = IDLE;
      count_nx   = clean;
      presc_nx   = '0;
      invalid_nx = clamp;
    end else
      case (state)
        IDLE:
          if (start) begin
            if (count != '0) state_nx = RUN;
            else done_nx = 1'b1;
          end
        RUN:
          if (pause) state_nx = PAUSE;
          else if (tick) begin
            if (presc == PW'(PRESCALE - 1)) begin
              presc_nx = '0;
              count_nx = dec;
              if (dec == '0) begin
                done_nx = 1'b1;
                if (reload_val != '0) count_nx = reload_val;
                else state_nx = IDLE;
              end
            end else presc_nx = presc + PW'(1);
          end
        PAUSE:
          if (start) state_nx = RUN;
        default: state_nx = IDLE;
      endcase
  end
  // busy is a decode of the upcoming state so it lines up with the registered state
  always_comb busy_nx = state_nx != IDLE;
endmodule

// File: tb/tb_bcd_down_counter.sv
// tb_bcd_down_counter: randomized and directed check of two counter instances (PRESCALE 1 and 4) against an integer reference model
module tb_bcd_down_counter;
  logic clk = 1'b0;
  logic rst_n, load, start, pause, tick;
  logic [11:0] load_val;
  logic [11:0] count_a, count_b;
  logic busy_a, busy_b, done_a, done_b, inv_a, inv_b;
  int n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;

  bcd_down_counter #(.DIGITS(3), .PRESCALE(1)) u_a (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val), .start(start),
    .pause(pause), .tick(tick), .count(count_a), .busy(busy_a), .done(done_a), .invalid(inv_a));
  bcd_down_counter #(.DIGITS(3), .PRESCALE(4)) u_b (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val), .start(start),
    .pause(pause), .tick(tick), .count(count_b), .busy(busy_b), .done(done_b), .invalid(inv_b));

  typedef struct {int v; int st; int pre; int rl; bit done; bit inv;} mdl_t;
  mdl_t ma, mb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r = '0;
    for (int i = 0; i < 3; i++) begin
      r[4*i+:4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // model: count held as a plain integer; states 0=idle 1=run 2=pause
  function automatic mdl_t step(input mdl_t m, input int p);
    int s = 0, mul = 1, d;
    bit cl = 0;
    if (!rst_n) return '{0, 0, 0, 0, 0, 0};
    m.done = 0;
    m.inv = 0;
    if (load) begin
      for (int i = 0; i < 3; i++) begin
        d = int'(load_val[4*i+:4]);
        if (d > 9) begin d = 9; cl = 1; end
        s += d * mul;
        mul *= 10;
      end
      m.v = s; m.st = 0; m.pre = 0; m.inv = cl;
`ifdef BCD_DOWN_RELOAD_EN
      m.rl = s;
`endif
    end else if (m.st == 0) begin
      if (start) begin
        if (m.v != 0) m.st = 1;
        else m.done = 1;
      end
    end else if (m.st == 1) begin
      if (pause) m.st = 2;
      else if (tick) begin
        if (m.pre == p - 1) begin
          m.pre = 0;
          m.v = m.v - 1;
          if (m.v == 0) begin
            m.done = 1;
            if (m.rl != 0) m.v = m.rl;
            else m.st = 0;
          end
        end else m.pre++;
      end
    end else if (start) m.st = 1;
    return m;
  endfunction

  task automatic cycle();
    @(posedge clk);
    ma = step(ma, 1);
    mb = step(mb, 4);
    #1;
    check("a.count", count_a, to_bcd(ma.v));
    check("a.busy", busy_a, ma.st != 0);
    check("a.done", done_a, ma.done);
    check("a.invalid", inv_a, ma.inv);
    check("b.count", count_b, to_bcd(mb.v));
    check("b.busy", busy_b, mb.st != 0);
    check("b.done", done_b, mb.done);
    check("b.invalid", inv_b, mb.inv);
  endtask

  task automatic drive(input bit rn, input bit ld, input logic [11:0] lv, input bit st, input bit ps, input bit tk);
    rst_n = rn; load = ld; load_val = lv; start = st; pause = ps; tick = tk;
    cycle();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 1);
  endtask

  initial begin
    ma = '{0, 0, 0, 0, 0, 0};
    mb = ma;
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    check("reset.count", count_a, 12'h000);
    // reset mid-run
    drive(1, 1, 12'h345, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 0);
    ticks(2);
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 0, 1);
    check("rst_mid.count", count_a, 12'h000);
    check("rst_mid.busy", busy_a, 1'b0);
    // borrow chain
    drive(1, 1, 12'h100, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 0);
    ticks(1);
    check("borrow.099", count_a, 12'h099);
    ticks(99);
    check("borrow.done", done_a, ma.done);
    // invalid load
    drive(1, 1, 12'h0A5, 0, 0, 0);
    check("inv.clamp", count_a, 12'h095);
    check("inv.pulse", inv_a, 1'b1);
    drive(1, 1, 12'h123, 0, 0, 0);
    check("inv.clean", inv_a, 1'b0);
    // prescale and pause on the PRESCALE=4 instance
    drive(1, 1, 12'h010, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 0);
    ticks(3);
    check("pre.hold", count_b, 12'h010);
    ticks(1);
    check("pre.dec", count_b, 12'h009);
    drive(1, 0, 0, 0, 1, 0);
    ticks(10);
    check("pause.hold", count_b, 12'h009);
    drive(1, 0, 0, 1, 0, 0);
    ticks(4);
    check("resume.dec", count_b, 12'h008);
    // zero start and load override
    drive(1, 1, 12'h000, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 0);
    check("zero.done", done_a, 1'b1);
    check("zero.busy", busy_a, 1'b0);
    drive(1, 1, 12'h030, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 0);
    drive(1, 1, 12'h050, 0, 0, 1);
    check("ovr.count", count_a, 12'h050);
    check("ovr.busy", busy_a, 1'b0);
    // reload-sensitive short run
    drive(1, 1, 12'h002, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 0);
    ticks(2);
    drive(1, 1, 12'h000, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 0);
    check("zero2.done", done_b, 1'b1);
    // randomized phase
    for (int n = 0; n < 3000; n++) begin
      logic [11:0] lv;
      lv = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 40));
      drive($urandom_range(0, 199) != 0, $urandom_range(0, 29) == 0, lv,
            $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 1) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
